serial_word_collector: RTL

- Bit-serial to parallel collector placed directly downstream of the serial two's-complement negator.
- Consumes the negator's LSB-first output stream and assembles WIDTH-bit words.
- Presents each word on a parallel bus with a one-cycle valid strobe, plus sign/zero status and a sticky overrun flag.
- Frame start is the same pulse that drives the negator's Reset, so both stages stay bit-aligned.

---
 rtl/serial_word_collector.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_word_collector.sv
// Bit-serial to parallel collector for the negator's LSB-first output stream.
// Assembles WIDTH-bit words and presents them with a one-cycle Valid strobe plus sign/zero/overrun status.
module serial_word_collector #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 6
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             En,
    input  logic             Start,
    input  logic             D,
    output logic [WIDTH-1:0] Q,
    output logic             Valid,
    output logic             Busy,
    output logic             Neg,
    output logic             Zero,
    output logic             Ovr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shift_q, shift_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] q_n;
    logic             valid_n;
    logic             busy_n;
    logic             neg_n;
    logic             zero_n;
    logic             ovr_n;
    logic [WIDTH-1:0] word_c;

    // Incoming bit enters at the top so the first bit received settles in bit 0.
    assign word_c = {D, shift_q[WIDTH-1:1]};

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= IDLE;
            shift_q <= '0;
            count   <= '0;
            Q       <= '0;
            Valid   <= 1'b0;
            Busy    <= 1'b0;
            Neg     <= 1'b0;
            Zero    <= 1'b1;
            Ovr     <= 1'b0;
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            count   <= count_n;
            Q       <= q_n;
            Valid   <= valid_n;
            Busy    <= busy_n;
            Neg     <= neg_n;
            Zero    <= zero_n;
            Ovr     <= ovr_n;
        end
    end

    // Next-state and next-output logic; Start overrides everything in every state.
    always_comb begin
        state_n = state;
        shift_n = shift_q;
        count_n = count;
        q_n     = Q;
        valid_n = 1'b0;
        neg_n   = Neg;
        zero_n  = Zero;
        ovr_n   = Ovr;

        if (Start) begin
            shift_n = '0;
            count_n = '0;
            ovr_n   = 1'b0;
            state_n = SHIFT;
        end else begin
            case (state)
                SHIFT: begin
                    if (En) begin
                        shift_n = word_c;
                        count_n = count + CW'(1);
                        if (count == CW'(WIDTH - 1)) begin
                            q_n     = word_c;
                            neg_n   = word_c[WIDTH-1];
                            zero_n  = (word_c == '0);
                            valid_n = 1'b1;
                            state_n = DONE;
                        end
                    end
                end
                DONE: begin
                    // Late bits are dropped but remembered as an overrun.
                    if (En) begin
                        ovr_n = 1'b1;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end

        busy_n = (state_n == SHIFT);
    end

endmodule
